// File: rtl/l2_arb_pkg.sv
// -----------------------------------------------------------------------------
// l2_arb_pkg
//   Shared types and defaults for the L2 / memory-port arbiter.
//   - arb_state_t : arbiter FSM states (IDLE, GRANT_I, GRANT_D)
//   - req_id_t    : requester identity, also the encoding of last_grant
//   - other_side(): the requester that is not the argument
// -----------------------------------------------------------------------------
package l2_arb_pkg;

  // Default line-port geometry: byte address, one full cache line per beat.
  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  function automatic req_id_t other_side(input req_id_t id);
    return (id == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage : l2_arb_pkg

// File: rtl/arb_rr_pick.sv
// -----------------------------------------------------------------------------
// arb_rr_pick
//   Two-way round-robin pick, purely combinational.
//   Ports:
//     req_i       in   I-cache side is requesting (stb & cyc)
//     req_d       in   D-cache side is requesting (stb & cyc)
//     last_grant  in   side that completed most recently; it loses a tie
//     grant_valid out  at least one side is requesting
//     grant_id    out  side to grant (only meaningful when grant_valid)
// -----------------------------------------------------------------------------
module arb_rr_pick
  import l2_arb_pkg::*;
(
  input  logic    req_i,
  input  logic    req_d,
  input  req_id_t last_grant,
  output logic    grant_valid,
  output req_id_t grant_id
);

  always_comb begin
    grant_valid = req_i | req_d;
    if (req_i && req_d) begin
      // Tie: the side that was served last waits.
      grant_id = other_side(last_grant);
    end else if (req_d) begin
      grant_id = REQ_D;
    end else begin
      grant_id = REQ_I;
    end
  end

endmodule : arb_rr_pick

// File: rtl/l2_mem_arbiter.sv
// -----------------------------------------------------------------------------
// l2_mem_arbiter
//   Shares one memory / L2 line port between the L1 I-cache and D-cache
//   controllers. Round-robin between the two sides; a grant is held for a
//   whole line transaction (until mem_resp, or until the owner drops cyc).
//
//   Ports (x = i or d):
//     clk, rst          single clock; synchronous active-high reset
//     x_stb, x_cyc      requester strobe / bus cycle (cyc low = abort)
//     x_write           requester write (D side: write-back)
//     x_addr, x_wdata   requester line address / write line
//     x_rdata           read line returned to the requester
//     x_resp            requester transaction complete
//     x_retry           requester pending, not complete
//     mem_stb, mem_cyc  memory strobe / bus cycle
//     mem_write         memory write
//     mem_addr          memory line address
//     mem_wdata         memory write line
//     mem_rdata         memory read line
//     mem_resp          memory transaction complete (1-cycle pulse)
//     mem_retry         memory busy; informational only, grant is held anyway
//
//   Timing: a request seen in IDLE in cycle N is on the memory port in
//   cycle N+1. Every grant is followed by exactly one IDLE cycle.
// -----------------------------------------------------------------------------
module l2_mem_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_stb,
  input  logic              i_cyc,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  output logic              i_retry,

  input  logic              d_stb,
  input  logic              d_cyc,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              d_retry,

  output logic              mem_stb,
  output logic              mem_cyc,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  input  logic              mem_retry
);

  arb_state_t state_q, state_d;
  req_id_t    last_grant_q, last_grant_d;

  logic       req_i, req_d;
  logic       pick_valid;
  req_id_t    pick_id;

  assign req_i = i_stb & i_cyc;
  assign req_d = d_stb & d_cyc;

  arb_rr_pick u_pick (
    .req_i       (req_i),
    .req_d       (req_d),
    .last_grant  (last_grant_q),
    .grant_valid (pick_valid),
    .grant_id    (pick_id)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state is written with <= only, so every flop samples pre-edge values
  // and the order of statements inside the block does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_D;   // I wins the first tie after reset
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  //   Completion (mem_resp) takes priority over abort (owner's cyc low), so a
  //   response arriving in the same cycle cyc falls still counts and rotates
  //   the priority. An abort leaves last_grant untouched.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default on the
  // first lines; a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = (pick_id == REQ_I) ? GRANT_I : GRANT_D;
        end
      end
      GRANT_I: begin
        if (mem_resp) begin
          state_d      = IDLE;
          last_grant_d = REQ_I;
        end else if (!i_cyc) begin
          state_d = IDLE;
        end
      end
      GRANT_D: begin
        if (mem_resp) begin
          state_d      = IDLE;
          last_grant_d = REQ_D;
        end else if (!d_cyc) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output muxes
  //   The granted side is wired straight through to the memory port; the
  //   requester keeps address/data stable while stb is high, so no capture
  //   registers are needed. mem_stb is qualified with cyc so that an abort
  //   drops both strobes in the same cycle. A waiting side sees retry while it
  //   requests and nothing else. While rst is high every output is forced low,
  //   so a grant that is being reset never leaks onto either port.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_stb   = 1'b0;
    mem_cyc   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_rdata   = '0;
    i_resp    = 1'b0;
    i_retry   = req_i;
    d_rdata   = '0;
    d_resp    = 1'b0;
    d_retry   = req_d;

    unique case (state_q)
      GRANT_I: begin
        mem_stb   = i_stb & i_cyc;
        mem_cyc   = i_cyc;
        mem_write = i_write;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        i_rdata   = mem_rdata;
        i_resp    = mem_resp;
        i_retry   = req_i & ~mem_resp;
      end
      GRANT_D: begin
        mem_stb   = d_stb & d_cyc;
        mem_cyc   = d_cyc;
        mem_write = d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_rdata   = mem_rdata;
        d_resp    = mem_resp;
        d_retry   = req_d & ~mem_resp;
      end
      default: begin
        // IDLE: memory port quiet, retry defaults already applied.
      end
    endcase

    if (rst) begin
      mem_stb   = 1'b0;
      mem_cyc   = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      i_rdata   = '0;
      i_resp    = 1'b0;
      i_retry   = 1'b0;
      d_rdata   = '0;
      d_resp    = 1'b0;
      d_retry   = 1'b0;
    end
  end

  // mem_retry only tells the requester the memory is busy; the grant is held
  // until mem_resp regardless, so it does not feed the FSM.
  logic unused_mem_retry;
  assign unused_mem_retry = mem_retry;

endmodule : l2_mem_arbiter

// File: tb/tb_l2_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l2_mem_arbiter
//   Cycle-by-cycle vector table covering reset, single grants, ties, retry,
//   abort, same-cycle completion/abort and reset mid-grant, followed by a
//   scoreboarded run of back-to-back contention (expected grant order pushed
//   when requests are driven, popped when mem_stb appears).
// -----------------------------------------------------------------------------
module tb_l2_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk;
  logic          rst;
  logic          i_stb, i_cyc, i_write;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_wdata, i_rdata;
  logic          i_resp, i_retry;
  logic          d_stb, d_cyc, d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata, d_rdata;
  logic          d_resp, d_retry;
  logic          mem_stb, mem_cyc, mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;
  logic          mem_resp, mem_retry;

  int checks = 0;
  int errors = 0;

  l2_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_stb     (i_stb),
    .i_cyc     (i_cyc),
    .i_write   (i_write),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .i_retry   (i_retry),
    .d_stb     (d_stb),
    .d_cyc     (d_cyc),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .d_retry   (d_retry),
    .mem_stb   (mem_stb),
    .mem_cyc   (mem_cyc),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp),
    .mem_retry (mem_retry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run must always end on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Write lines are derived from the address so each side's data is distinct.
  function automatic logic [LW-1:0] i_line(input logic [AW-1:0] a);
    return {8{a ^ 32'h1111_0000}};
  endfunction

  function automatic logic [LW-1:0] d_line(input logic [AW-1:0] a);
    return {8{a ^ 32'h2222_0000}};
  endfunction

  localparam logic [LW-1:0] RD_LINE = {32{8'hAA}};

  // One row = one clock cycle of inputs and the outputs expected in it.
  // e_ctl = {mem_stb, mem_cyc, i_resp, i_retry, d_resp, d_retry}
  // e_src = 0: memory port idle, 1: I side routed, 2: D side routed
  typedef struct {
    logic          rst;
    logic          is, ic, iw;
    logic [AW-1:0] ia;
    logic          ds, dc, dw;
    logic [AW-1:0] da;
    logic          resp, retry;
    logic [5:0]    e_ctl;
    logic [1:0]    e_src;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic is, input logic ic, input logic iw,
                              input logic [AW-1:0] ia, input logic ds, input logic dc,
                              input logic dw, input logic [AW-1:0] da, input logic resp,
                              input logic retry, input logic [5:0] ctl, input logic [1:0] src);
    vec_t v;
    v.rst = r; v.is = is; v.ic = ic; v.iw = iw; v.ia = ia;
    v.ds = ds; v.dc = dc; v.dw = dw; v.da = da;
    v.resp = resp; v.retry = retry; v.e_ctl = ctl; v.e_src = src;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst       = v.rst;
    i_stb     = v.is;
    i_cyc     = v.ic;
    i_write   = v.iw;
    i_addr    = v.ia;
    i_wdata   = i_line(v.ia);
    d_stb     = v.ds;
    d_cyc     = v.dc;
    d_write   = v.dw;
    d_addr    = v.da;
    d_wdata   = d_line(v.da);
    mem_resp  = v.resp;
    mem_retry = v.retry;
    mem_rdata = RD_LINE;
  endtask

  task automatic compare_row(input int r, input vec_t v);
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wdata, e_ird, e_drd;
    logic          e_write;
    e_addr  = '0;
    e_wdata = '0;
    e_write = 1'b0;
    e_ird   = '0;
    e_drd   = '0;
    if (v.e_src == 2'd1) begin
      e_addr = v.ia; e_wdata = i_line(v.ia); e_write = v.iw; e_ird = RD_LINE;
    end else if (v.e_src == 2'd2) begin
      e_addr = v.da; e_wdata = d_line(v.da); e_write = v.dw; e_drd = RD_LINE;
    end
    check($sformatf("row%0d_ctl", r),
          LW'({mem_stb, mem_cyc, i_resp, i_retry, d_resp, d_retry}), LW'(v.e_ctl));
    check($sformatf("row%0d_mem_addr", r),  LW'(mem_addr), LW'(e_addr));
    check($sformatf("row%0d_mem_wdata", r), mem_wdata, e_wdata);
    check($sformatf("row%0d_mem_write", r), LW'(mem_write), LW'(e_write));
    check($sformatf("row%0d_i_rdata", r),   i_rdata, e_ird);
    check($sformatf("row%0d_d_rdata", r),   d_rdata, e_drd);
  endtask

  // Scoreboard for back-to-back contention.
  typedef struct {
    logic          id;     // 0 = I, 1 = D
    logic [AW-1:0] addr;
  } exp_t;

  exp_t sb[$];

  initial begin
    rst = 1'b1;
    i_stb = 0; i_cyc = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    d_stb = 0; d_cyc = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 0; mem_retry = 0;

    //              rst is ic iw ia         ds dc dw da          rsp rty ctl        src
    // Reset, single I read at 0x100
    vecs.push_back(mk(1, 0,0,0, 32'h0100,  0,0,0, 32'h2000,  0,0, 6'b000000, 2'd0)); // 0
    vecs.push_back(mk(0, 1,1,0, 32'h0100,  0,0,0, 32'h2000,  0,0, 6'b000100, 2'd0)); // 1 IDLE sees req
    vecs.push_back(mk(0, 1,1,0, 32'h0100,  0,0,0, 32'h2000,  0,0, 6'b110100, 2'd1)); // 2 granted N+1
    vecs.push_back(mk(0, 1,1,0, 32'h0100,  0,0,0, 32'h2000,  1,0, 6'b111000, 2'd1)); // 3 resp
    vecs.push_back(mk(0, 0,0,0, 32'h0100,  0,0,0, 32'h2000,  0,0, 6'b000000, 2'd0)); // 4
    // Reset, simultaneous I and D: I first, D after one bubble
    vecs.push_back(mk(1, 0,0,0, 32'h0140,  0,0,1, 32'h2040,  0,0, 6'b000000, 2'd0)); // 5
    vecs.push_back(mk(0, 1,1,0, 32'h0140,  1,1,1, 32'h2040,  0,0, 6'b000101, 2'd0)); // 6 tie
    vecs.push_back(mk(0, 1,1,0, 32'h0140,  1,1,1, 32'h2040,  0,0, 6'b110101, 2'd1)); // 7
    vecs.push_back(mk(0, 1,1,0, 32'h0140,  1,1,1, 32'h2040,  1,0, 6'b111001, 2'd1)); // 8
    vecs.push_back(mk(0, 0,0,0, 32'h0140,  1,1,1, 32'h2040,  0,0, 6'b000001, 2'd0)); // 9 bubble
    vecs.push_back(mk(0, 0,0,0, 32'h0140,  1,1,1, 32'h2040,  0,0, 6'b110001, 2'd2)); // 10
    vecs.push_back(mk(0, 0,0,0, 32'h0140,  1,1,1, 32'h2040,  1,0, 6'b110010, 2'd2)); // 11
    vecs.push_back(mk(0, 0,0,0, 32'h0140,  0,0,0, 32'h2040,  0,0, 6'b000000, 2'd0)); // 12
    // D write-back at 0x2000 with 5 cycles of mem_retry; I arrives meanwhile
    vecs.push_back(mk(0, 0,0,0, 32'h0100,  1,1,1, 32'h2000,  0,0, 6'b000001, 2'd0)); // 13
    vecs.push_back(mk(0, 0,0,0, 32'h0100,  1,1,1, 32'h2000,  0,1, 6'b110001, 2'd2)); // 14
    vecs.push_back(mk(0, 1,1,0, 32'h0100,  1,1,1, 32'h2000,  0,1, 6'b110101, 2'd2)); // 15
    vecs.push_back(mk(0, 1,1,0, 32'h0100,  1,1,1, 32'h2000,  0,1, 6'b110101, 2'd2)); // 16
    vecs.push_back(mk(0, 1,1,0, 32'h0100,  1,1,1, 32'h2000,  0,1, 6'b110101, 2'd2)); // 17
    vecs.push_back(mk(0, 1,1,0, 32'h0100,  1,1,1, 32'h2000,  0,1, 6'b110101, 2'd2)); // 18
    vecs.push_back(mk(0, 1,1,0, 32'h0100,  1,1,1, 32'h2000,  1,0, 6'b110110, 2'd2)); // 19 resp
    // Tie (last=D) -> I; I aborts two cycles into the grant
    vecs.push_back(mk(0, 1,1,0, 32'h0100,  1,1,0, 32'h2080,  0,0, 6'b000101, 2'd0)); // 20
    vecs.push_back(mk(0, 1,1,0, 32'h0100,  1,1,0, 32'h2080,  0,0, 6'b110101, 2'd1)); // 21
    vecs.push_back(mk(0, 1,1,0, 32'h0100,  1,1,0, 32'h2080,  0,0, 6'b110101, 2'd1)); // 22
    vecs.push_back(mk(0, 1,0,0, 32'h0100,  1,1,0, 32'h2080,  0,0, 6'b000001, 2'd1)); // 23 abort
    // Abort left last_grant at D: a fresh tie still goes to I
    vecs.push_back(mk(0, 1,1,0, 32'h0180,  1,1,0, 32'h2080,  0,0, 6'b000101, 2'd0)); // 24
    vecs.push_back(mk(0, 1,1,0, 32'h0180,  1,1,0, 32'h2080,  0,0, 6'b110101, 2'd1)); // 25
    vecs.push_back(mk(0, 1,1,0, 32'h0180,  1,1,0, 32'h2080,  1,0, 6'b111001, 2'd1)); // 26
    vecs.push_back(mk(0, 0,0,0, 32'h0180,  1,1,0, 32'h2080,  0,0, 6'b000001, 2'd0)); // 27
    vecs.push_back(mk(0, 0,0,0, 32'h0180,  1,1,0, 32'h2080,  0,0, 6'b110001, 2'd2)); // 28
    // mem_resp and d_cyc fall together: completion, last_grant -> D
    vecs.push_back(mk(0, 0,0,0, 32'h0180,  1,0,0, 32'h2080,  1,0, 6'b000010, 2'd2)); // 29
    vecs.push_back(mk(0, 1,1,0, 32'h01C0,  1,1,1, 32'h20C0,  0,0, 6'b000101, 2'd0)); // 30 tie -> I
    vecs.push_back(mk(0, 1,1,0, 32'h01C0,  1,1,1, 32'h20C0,  0,0, 6'b110101, 2'd1)); // 31
    vecs.push_back(mk(0, 1,1,0, 32'h01C0,  1,1,1, 32'h20C0,  1,0, 6'b111001, 2'd1)); // 32
    // Reset while D holds the port
    vecs.push_back(mk(0, 0,0,0, 32'h01C0,  1,1,1, 32'h20C0,  0,0, 6'b000001, 2'd0)); // 33
    vecs.push_back(mk(0, 0,0,0, 32'h01C0,  1,1,1, 32'h20C0,  0,0, 6'b110001, 2'd2)); // 34
    vecs.push_back(mk(1, 0,0,0, 32'h01C0,  1,1,1, 32'h20C0,  0,0, 6'b000000, 2'd0)); // 35 rst
    vecs.push_back(mk(0, 0,0,0, 32'h01C0,  1,1,1, 32'h20C0,  0,0, 6'b000001, 2'd0)); // 36 IDLE
    vecs.push_back(mk(0, 0,0,0, 32'h01C0,  1,1,1, 32'h20C0,  0,0, 6'b110001, 2'd2)); // 37
    vecs.push_back(mk(0, 0,0,0, 32'h01C0,  1,1,1, 32'h20C0,  1,0, 6'b110010, 2'd2)); // 38
    vecs.push_back(mk(0, 0,0,0, 32'h01C0,  0,0,0, 32'h20C0,  0,0, 6'b000000, 2'd0)); // 39

    @(posedge clk);
    for (int r = 0; r < vecs.size(); r++) begin
      @(posedge clk);
      #1;
      apply(vecs[r]);
      @(negedge clk);
      compare_row(r, vecs[r]);
    end

    // ---------------------------------------------------------------------
    // Continuous contention: four transactions, expected order I,D,I,D,
    // each grant preceded by exactly one IDLE cycle.
    // ---------------------------------------------------------------------
    begin
      logic model_last;
      logic got;
      int   idle;
      exp_t e;

      @(posedge clk);
      #1;
      rst = 1'b1; mem_resp = 0; mem_retry = 0;
      i_stb = 0; i_cyc = 0; d_stb = 0; d_cyc = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_last = 1'b1;                 // D after reset
      i_addr = 32'h3000; i_wdata = i_line(32'h3000); i_write = 0;
      d_addr = 32'h4000; d_wdata = d_line(32'h4000); d_write = 1;
      i_stb = 1; i_cyc = 1; d_stb = 1; d_cyc = 1;
      e.id = ~model_last;
      e.addr = e.id ? d_addr : i_addr;
      sb.push_back(e);

      for (int t = 0; t < 4; t++) begin
        idle = 0;
        got  = 1'b0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (mem_stb) begin
            got = 1'b1;
            break;
          end
          idle++;
        end
        if (!got) begin
          checks++;
          errors++;
          $display("FAIL sb%0d_grant_timeout got no mem_stb expected mem_stb within 10 cycles", t);
          break;
        end
        e = sb.pop_front();
        check($sformatf("sb%0d_bubble", t),    LW'(idle),      LW'(1));
        check($sformatf("sb%0d_mem_addr", t),  LW'(mem_addr),  LW'(e.addr));
        check($sformatf("sb%0d_mem_write", t), LW'(mem_write), LW'(e.id));
        check($sformatf("sb%0d_loser_retry", t),
              LW'(e.id ? i_retry : d_retry), LW'(1));

        @(posedge clk);
        #1;
        mem_resp = 1'b1;
        @(posedge clk);
        #1;
        mem_resp   = 1'b0;
        model_last = e.id;
        // Winner moves on to its next line; both sides keep requesting.
        if (e.id) begin
          d_addr = d_addr + 32'h40; d_wdata = d_line(d_addr);
        end else begin
          i_addr = i_addr + 32'h40; i_wdata = i_line(i_addr);
        end
        if (t < 3) begin
          e.id   = ~model_last;
          e.addr = e.id ? d_addr : i_addr;
          sb.push_back(e);
        end
      end
      check("sb_drained", LW'(sb.size()), LW'(0));

      @(posedge clk);
      #1;
      i_stb = 0; i_cyc = 0; d_stb = 0; d_cyc = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_l2_mem_arbiter
